seq_mon: RTL and testbench

//  Cycle-by-cycle checker for a per-cycle waveform pattern string; the receiving end of the seq pattern generator.

---
 rtl/seq_mon_pkg.sv | 47 ++++
 rtl/seq_mon.sv | 125 ++++++++++++
 tb/tb_seq_mon.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mon_pkg.sv
// Shared helpers for the seq pattern generator and monitor: character decoding
// of the per-cycle waveform string and the monitor's state type.
package seq_pkg;

   localparam byte SEQ_DC_CHAR = ".";

   typedef enum logic {
      SEQ_RUN  = 1'b0,
      SEQ_DONE = 1'b1
   } seq_state_t;

   function automatic logic [3:0] seq_char_val(byte c);
      int v;
      v = int'(c);
      if (v >= 48 && v <= 57) begin
         return 4'(v - 48);
      end
      if (v >= 97 && v <= 102) begin
         return 4'(v - 87);
      end
      if (c == "-") begin
         return 4'd1;
      end
      return 4'd0;
   endfunction

   function automatic logic seq_char_dc(byte c);
      return c == SEQ_DC_CHAR;
   endfunction

   // Level chars only make sense on a single bit; digits must fit in width.
   function automatic logic seq_char_legal(byte c, int width);
      int v;
      v = int'(c);
      if (c == "_" || c == "-") begin
         return width == 1;
      end
      if (c == SEQ_DC_CHAR) begin
         return 1'b1;
      end
      if ((v >= 48 && v <= 57) || (v >= 97 && v <= 102)) begin
         return int'(seq_char_val(c)) < (1 << width);
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/seq_mon.sv
// Golden-waveform checker: compares a sampled signal against a per-cycle
// pattern string and records mismatch statistics and the first failure.
module seq_mon
   import seq_pkg::*;
#(
   parameter PATTERN = "",
   parameter int WIDTH = 1,
   parameter int ERR_MAX = 255,
   localparam int LEN = (PATTERN == '0) ? 0 : $bits(PATTERN) / 8,
   localparam int IW = (LEN == 0) ? 1 : $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] sig,
   output logic [IW-1:0]    idx,
   output logic             active,
   output logic             done,
   output logic             mismatch,
   output logic             fail,
   output logic [7:0]       err_cnt,
   output logic [IW-1:0]    first_err_idx,
   output logic [WIDTH-1:0] first_err_val
);

   localparam int DEPTH = (LEN == 0) ? 1 : LEN;
   localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
   localparam logic [IW-1:0] LEN_IDX = IW'(LEN);
   localparam logic [7:0] ERR_SAT = 8'(ERR_MAX);

   logic [WIDTH-1:0] expVal [DEPTH];
   logic             dcMask [DEPTH];

   if (WIDTH < 1 || WIDTH > 4) begin : g_bad_width
      $error("seq_mon: WIDTH %0d outside 1..4", WIDTH);
   end

   // String char 0 sits in the most significant byte of the packed literal.
   for (genvar k = 0; k < LEN; k++) begin : g_dec
      localparam byte CH = byte'(PATTERN[8*(LEN-1-k) +: 8]);
      if (!seq_char_legal(CH, WIDTH)) begin : g_bad_char
         $error("seq_mon: illegal pattern char at index %0d for WIDTH %0d", k, WIDTH);
      end
      assign expVal[k] = WIDTH'(seq_char_val(CH));
      assign dcMask[k] = seq_char_dc(CH);
   end

   if (LEN == 0) begin : g_empty
      assign expVal[0] = '0;
      assign dcMask[0] = 1'b1;
   end

   seq_state_t       state_q;
   logic [IW-1:0]    idx_q;
   logic             done_q;
   logic             mismatch_q;
   logic             fail_q;
   logic [7:0]       errCnt_q;
   logic [IW-1:0]    firstIdx_q;
   logic [WIDTH-1:0] firstVal_q;

   logic [WIDTH-1:0] curExp;
   logic             curDc;
   logic             mismatch_d;

   always_comb begin
      curExp = '0;
      curDc  = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         if (idx_q == IW'(k)) begin
            curExp = expVal[k];
            curDc  = dcMask[k];
         end
      end
      mismatch_d = !curDc && (sig !== curExp);
   end

   // An empty pattern skips RUN entirely and reports done from the first edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= (LEN == 0) ? SEQ_DONE : SEQ_RUN;
         idx_q      <= '0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
         fail_q     <= 1'b0;
         errCnt_q   <= 8'd0;
         firstIdx_q <= '0;
         firstVal_q <= '0;
      end else begin
         case (state_q)
            SEQ_RUN: begin
               idx_q      <= idx_q + 1'b1;
               mismatch_q <= mismatch_d;
               if (mismatch_d) begin
                  fail_q <= 1'b1;
                  if (!fail_q) begin
                     firstIdx_q <= idx_q;
                     firstVal_q <= sig;
                  end
                  if (errCnt_q < ERR_SAT) begin
                     errCnt_q <= errCnt_q + 8'd1;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= SEQ_DONE;
                  done_q  <= 1'b1;
               end
            end
            SEQ_DONE: begin
               mismatch_q <= 1'b0;
               done_q     <= 1'b1;
            end
         endcase
      end
   end

   assign idx           = idx_q;
   assign active        = idx_q < LEN_IDX;
   assign done          = done_q;
   assign mismatch      = mismatch_q;
   assign fail          = fail_q;
   assign err_cnt       = errCnt_q;
   assign first_err_idx = firstIdx_q;
   assign first_err_val = firstVal_q;

endmodule

// File: tb/tb_seq_mon.sv
// Scoreboard bench for seq_mon: three instances (hex pattern with saturation,
// level pattern, empty pattern) checked against a string-level reference model.
module tb_seq_mon;

   typedef struct {
      int idx;
      int active;
      int done;
      int mismatch;
      int fail;
      int errCnt;
      int firstIdx;
      int firstVal;
   } exp_t;

   string pat0 = "1.3a0f";
   string pat1 = "__-_";
   string pat2 = "";
   localparam int ERR0 = 3;
   localparam int ERR1 = 255;
   localparam int ERR2 = 255;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [3:0] sig0 = '0;
   logic sig1 = 1'b0;
   logic sig2 = 1'b0;

   logic [2:0] idx0, firstIdx0;
   logic [2:0] idx1, firstIdx1;
   logic [0:0] idx2, firstIdx2;
   logic active0, done0, mismatch0, fail0;
   logic active1, done1, mismatch1, fail1;
   logic active2, done2, mismatch2, fail2;
   logic [7:0] errCnt0, errCnt1, errCnt2;
   logic [3:0] firstVal0;
   logic firstVal1, firstVal2;

   int vectors = 0;
   int miscompares = 0;

   int s0[$];
   int s1[$];
   int s2[$];
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   seq_mon #(.PATTERN("1.3a0f"), .WIDTH(4), .ERR_MAX(ERR0)) u0 (
      .clk(clk), .rstn(rstn), .sig(sig0), .idx(idx0), .active(active0),
      .done(done0), .mismatch(mismatch0), .fail(fail0), .err_cnt(errCnt0),
      .first_err_idx(firstIdx0), .first_err_val(firstVal0)
   );

   seq_mon #(.PATTERN("__-_"), .WIDTH(1), .ERR_MAX(ERR1)) u1 (
      .clk(clk), .rstn(rstn), .sig(sig1), .idx(idx1), .active(active1),
      .done(done1), .mismatch(mismatch1), .fail(fail1), .err_cnt(errCnt1),
      .first_err_idx(firstIdx1), .first_err_val(firstVal1)
   );

   seq_mon #(.PATTERN(""), .WIDTH(1), .ERR_MAX(ERR2)) u2 (
      .clk(clk), .rstn(rstn), .sig(sig2), .idx(idx2), .active(active2),
      .done(done2), .mismatch(mismatch2), .fail(fail2), .err_cnt(errCnt2),
      .first_err_idx(firstIdx2), .first_err_val(firstVal2)
   );

   always #5 clk = ~clk;

   // Expected value of pattern char k, or -1 for don't care.
   function automatic int charExp(string p, int k);
      int c;
      c = int'(p[k]);
      if (c == 46) return -1;
      if (c == 95) return 0;
      if (c == 45) return 1;
      if (c >= 48 && c <= 57) return c - 48;
      return c - 87;
   endfunction

   // Outputs expected once the samples in s have been taken since reset.
   function automatic exp_t model(string p, int errMax, int s[$]);
      exp_t e;
      int len, n, cmp, cnt, ex;
      len = p.len();
      n = s.size();
      cmp = (n < len) ? n : len;
      cnt = 0;
      e.idx = cmp;
      e.active = (cmp < len) ? 1 : 0;
      e.done = (n >= 1 && n >= len) ? 1 : 0;
      e.mismatch = 0;
      e.fail = 0;
      e.firstIdx = 0;
      e.firstVal = 0;
      for (int k = 0; k < cmp; k++) begin
         ex = charExp(p, k);
         if (ex >= 0 && s[k] != ex) begin
            if (e.fail == 0) begin
               e.firstIdx = k;
               e.firstVal = s[k];
            end
            e.fail = 1;
            cnt++;
            if (k == n - 1) e.mismatch = 1;
         end
      end
      e.errCnt = (cnt < errMax) ? cnt : errMax;
      return e;
   endfunction

   function automatic int pickVal(string p, int k, int width, bit forceMatch);
      int ex;
      if (k < p.len() && forceMatch) begin
         ex = charExp(p, k);
         if (ex >= 0) return ex;
      end
      return int'($urandom_range((1 << width) - 1, 0));
   endfunction

   task automatic cmpField(string nm, int got, int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
      end
   endtask

   task automatic checkOutput(string nm, exp_t g, exp_t e);
      cmpField({nm, ".idx"}, g.idx, e.idx);
      cmpField({nm, ".active"}, g.active, e.active);
      cmpField({nm, ".done"}, g.done, e.done);
      cmpField({nm, ".mismatch"}, g.mismatch, e.mismatch);
      cmpField({nm, ".fail"}, g.fail, e.fail);
      cmpField({nm, ".err_cnt"}, g.errCnt, e.errCnt);
      cmpField({nm, ".first_err_idx"}, g.firstIdx, e.firstIdx);
      cmpField({nm, ".first_err_val"}, g.firstVal, e.firstVal);
   endtask

   function automatic exp_t grab(int i, int a, int d, int m, int f, int c, int fi, int fv);
      exp_t g;
      g.idx = i; g.active = a; g.done = d; g.mismatch = m;
      g.fail = f; g.errCnt = c; g.firstIdx = fi; g.firstVal = fv;
      return g;
   endfunction

   task automatic pushExpected();
      q0.push_back(model(pat0, ERR0, s0));
      q1.push_back(model(pat1, ERR1, s1));
      q2.push_back(model(pat2, ERR2, s2));
   endtask

   // Monitor: one expectation per instance per clock, sampled after the edge.
   initial begin
      exp_t e0, e1, e2;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            checkOutput("u0", grab(int'(idx0), int'(active0), int'(done0), int'(mismatch0),
                        int'(fail0), int'(errCnt0), int'(firstIdx0), int'(firstVal0)), e0);
            checkOutput("u1", grab(int'(idx1), int'(active1), int'(done1), int'(mismatch1),
                        int'(fail1), int'(errCnt1), int'(firstIdx1), int'(firstVal1)), e1);
            checkOutput("u2", grab(int'(idx2), int'(active2), int'(done2), int'(mismatch2),
                        int'(fail2), int'(errCnt2), int'(firstIdx2), int'(firstVal2)), e2);
         end
      end
   end

   task automatic resetPulse();
      @(negedge clk);
      rstn = 1'b0;
      #1;
      cmpField("u0.async_idx", int'(idx0), 0);
      cmpField("u0.async_fail", int'(fail0), 0);
      cmpField("u0.async_err_cnt", int'(errCnt0), 0);
      cmpField("u1.async_fail", int'(fail1), 0);
      cmpField("u1.async_mismatch", int'(mismatch1), 0);
      s0.delete();
      s1.delete();
      s2.delete();
      pushExpected();
   endtask

   // mode 0: each char matched with 50% odds, 1: directed, 2: fully random.
   task automatic applyStimulus(int cycles, int mode);
      int v0, v1, v2, k;
      bit fm;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         rstn = 1'b1;
         k = s0.size();
         fm = (mode == 1) || (mode == 0 && $urandom_range(1, 0) == 1);
         v0 = pickVal(pat0, k, 4, fm);
         v1 = pickVal(pat1, k, 1, fm);
         v2 = pickVal(pat2, k, 1, fm);
         if (mode == 1) v1 = (k == 2) ? 1 : 0;
         sig0 = 4'(v0);
         sig1 = v1[0];
         sig2 = v2[0];
         s0.push_back(v0);
         s1.push_back(v1);
         s2.push_back(v2);
         pushExpected();
      end
   endtask

   initial begin
      resetPulse();
      applyStimulus(8, 1);
      resetPulse();
      applyStimulus(9, 2);
      resetPulse();
      applyStimulus(3, 2);
      resetPulse();
      for (int r = 0; r < 40; r++) begin
         applyStimulus(int'($urandom_range(9, 1)), (r % 3 == 0) ? 2 : 0);
         resetPulse();
      end
      applyStimulus(10, 0);
      @(negedge clk);
      repeat (2) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
